// File: rtl/period_meter.sv
// period_meter: measures the period of a pulse train in clock_in cycles
// Ports:
//    clock_in   - system clock
//    clear      - asynchronous active-high reset
//    enable     - measurement enable; low parks the block in IDLE
//    pulse_in   - asynchronous pulse train; rising edges delimit periods
//    period_out - last measured period in clock_in cycles
//    valid      - one-cycle strobe when period_out updates
//    overflow   - sticky: no edge arrived within 2^WIDTH-1 cycles
//    locked     - high when the last two measured periods are equal
module period_meter #(
   parameter int WIDTH       = 26,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock_in,
   input  logic             clear,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [WIDTH-1:0] period_out,
   output logic             valid,
   output logic             overflow,
   output logic             locked
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] MEASURE = 2'd2;
   localparam logic [WIDTH-1:0] MAX = '1;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [1:0]             r_state;
   logic [WIDTH-1:0]       r_count;
   logic [WIDTH-1:0]       r_last;
   logic                   w_edge;
   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
   // The synchroniser runs regardless of enable so that re-enabling while
   // pulse_in is already high cannot fabricate an edge.
   always_ff @(posedge clock_in or posedge clear) begin
      if (clear) begin
         r_sync     <= '0;
         r_prev     <= 1'b0;
         r_state    <= IDLE;
         r_count    <= '0;
         r_last     <= '0;
         period_out <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
         r_prev <= r_sync[SYNC_STAGES-1];
         valid  <= 1'b0;
         if (r_state == IDLE) begin
            r_count <= '0;
            if (enable) begin
               r_state <= ARMED;
               locked  <= 1'b0;
            end
         end else if (!enable) begin
            r_state <= IDLE;
            r_count <= '0;
            locked  <= 1'b0;
         end else if (r_state == ARMED) begin
            if (w_edge) begin
               r_state <= MEASURE;
               r_count <= {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end else if (w_edge) begin
            // An edge on the terminal count still wins over overflow.
            period_out <= r_count;
            valid      <= 1'b1;
            overflow   <= 1'b0;
            locked     <= (r_last != '0) && (r_count == r_last);
            r_last     <= r_count;
            r_count    <= {{(WIDTH-1){1'b0}}, 1'b1};
         end else if (r_count == MAX) begin
            overflow <= 1'b1;
            locked   <= 1'b0;
            r_last   <= '0;
            r_state  <= ARMED;
            r_count  <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: scoreboard bench for period_meter (WIDTH=4)
module tb_period_meter;
   typedef struct packed {
      logic [3:0] p;
      logic       l;
   } exp_t;
   logic       clk = 1'b0;
   logic       clear, enable, pulse_in;
   logic [3:0] period_out;
   logic       valid, overflow, locked;
   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         m_prev = 0;
   always #5 clk = ~clk;
   period_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut (
      .clock_in(clk), .clear(clear), .enable(enable), .pulse_in(pulse_in),
      .period_out(period_out), .valid(valid), .overflow(overflow), .locked(locked)
   );
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic expect_period(int p);
      exp_t e;
      e.p = p[3:0];
      e.l = (m_prev != 0) && (p == m_prev);
      q.push_back(e);
      m_prev = p;
   endtask
   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pg(int n, bit e);
      if (e) expect_period(n);
      pulse_in = 1'b1;
      cyc(1);
      pulse_in = 1'b0;
      cyc(n - 1);
   endtask
   task automatic start();
      enable = 1'b1;
      cyc(2);
   endtask
   task automatic stop();
      cyc(3);
      enable = 1'b0;
      cyc(2);
   endtask
   initial begin
      exp_t e;
      logic vprev;
      vprev = 1'b0;
      forever begin
         @(negedge clk);
         if (valid) begin
            chk("valid_one_cycle", int'(vprev), 0);
            chk("valid_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("period", int'(period_out), int'(e.p));
               chk("locked", int'(locked), int'(e.l));
               chk("overflow_on_valid", int'(overflow), 0);
            end
         end
         vprev = valid;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      clear = 1'b1;
      enable = 1'b0;
      pulse_in = 1'b0;
      cyc(3);
      chk("rst_period", int'(period_out), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_locked", int'(locked), 0);
      clear = 1'b0;
      cyc(2);
      start();
      repeat (4) pg(5, 1);
      pg(2, 0);
      cyc(3);
      chk("t1_overflow", int'(overflow), 0);
      stop();
      start();
      repeat (3) pg(2, 1);
      pg(7, 1);
      pg(7, 1);
      pg(2, 0);
      stop();
      start();
      pulse_in = 1'b1;
      cyc(1);
      pulse_in = 1'b0;
      cyc(14);
      chk("t3_no_ovf_yet", int'(overflow), 0);
      cyc(5);
      chk("t3_overflow", int'(overflow), 1);
      chk("t3_period_hold", int'(period_out), 7);
      m_prev = 0;
      pg(6, 1);
      pg(6, 0);
      chk("t3_ovf_cleared", int'(overflow), 0);
      stop();
      start();
      pg(15, 1);
      pg(2, 0);
      cyc(3);
      chk("t3_15_no_ovf", int'(overflow), 0);
      chk("t3_15_queue", int'(q.size()), 0);
      stop();
      start();
      pg(4, 1);
      pg(4, 1);
      pg(2, 0);
      cyc(3);
      #2 clear = 1'b1;
      #1;
      chk("t4_clr_period", int'(period_out), 0);
      chk("t4_clr_valid", int'(valid), 0);
      chk("t4_clr_overflow", int'(overflow), 0);
      chk("t4_clr_locked", int'(locked), 0);
      #9 clear = 1'b0;
      m_prev = 0;
      @(negedge clk);
      pg(3, 1);
      pg(2, 0);
      stop();
      start();
      pg(5, 1);
      pg(5, 1);
      pg(5, 0);
      enable = 1'b0;
      cyc(2);
      chk("t5_lock_drop", int'(locked), 0);
      pulse_in = 1'b1;
      cyc(4);
      enable = 1'b1;
      cyc(4);
      chk("t5_lock_reen", int'(locked), 0);
      pulse_in = 1'b0;
      cyc(3);
      pg(9, 1);
      pg(2, 0);
      stop();
      start();
      pulse_in = 1'b1;
      cyc(10);
      chk("t6_no_ovf_yet", int'(overflow), 0);
      cyc(8);
      chk("t6_overflow", int'(overflow), 1);
      chk("t6_period_hold", int'(period_out), 9);
      chk("t6_locked", int'(locked), 0);
      m_prev = 0;
      pulse_in = 1'b0;
      enable = 1'b0;
      cyc(5);
      chk("final_queue", int'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period, in clock_in cycles, of a periodic pulse train on pulse_in.
- This is the receiving end of the rate-divider tick interface: a tick stream generated with load value D reads back as period D.
- Used to check divided clocks on hardware and to recover the rate of external pulse sources.
- Publishes each measurement with a one-cycle valid strobe, plus overflow and lock flags.

Parameters:
WIDTH, 26, width of the cycle counter and of period_out (matches the divider load width)
SYNC_STAGES, 2, number of flip-flops in the pulse_in synchroniser (minimum 2)

Ports:
clock_in  input  1  system clock
clear  input  1  asynchronous, active-high reset
enable  input  1  measurement enable; low parks the block in IDLE
pulse_in  input  1  asynchronous pulse train; rising edges delimit periods
period_out  output  WIDTH  last measured period in clock_in cycles
valid  output  1  one-cycle strobe when period_out updates
overflow  output  1  sticky flag: no edge arrived within 2^WIDTH-1 cycles
locked  output  1  high when the last two measured periods are equal

Behaviour:
- Clocking and reset:
  - Single clock domain on clock_in. Reset is asynchronous and active-high (clear).
  - While clear is high: all state returns to reset values immediately.
  - Reset values: period_out=0, valid=0, overflow=0, locked=0, counter=0, previous period=0, synchroniser=0, FSM=IDLE.
- Synchroniser and edge detection:
  - pulse_in passes through SYNC_STAGES flops, then one more flop for edge detection.
  - edge = sync_out & ~sync_prev.
  - Edge detection latency is SYNC_STAGES+1 cycles. This latency is constant, so it cancels out of period measurements.
- FSM states:
  - IDLE: counter held at 0, outputs held. enable=1 -> ARMED.
  - ARMED: waiting for the first edge; counter held at 0. edge -> MEASURE with counter<=1. enable=0 -> IDLE.
  - MEASURE:
    - No edge: counter increments.
    - edge: period_out<=counter, valid<=1 next cycle, counter<=1, stay in MEASURE.
    - enable=0 -> IDLE (any partial count is discarded, no valid).
- Period definition:
  - If detected edges occur at cycles t0 and t1, the reported period is t1-t0.
  - The minimum measurable period is 2 (pulse high one cycle, low one cycle).
  - A pulse_in held constantly high yields only one edge, so no measurement is produced.
- valid:
  - Exactly one cycle wide per measurement.
  - Never asserted for the first edge after ARMED.
- locked:
  - Updated together with valid.
  - locked<=(counter==previous period) when previous period is nonzero; previous period<=counter.
  - Cleared on entry to IDLE or ARMED, and on overflow.
- Overflow:
  - In MEASURE, if counter reaches 2^WIDTH-1 with no edge: overflow<=1, locked<=0, previous period<=0, FSM -> ARMED, counter<=0.
  - period_out is left unchanged.
  - An edge in the same cycle the counter reaches the maximum takes priority: it is a valid measurement of 2^WIDTH-1, and overflow is not set.
- overflow is sticky. It clears on the next valid measurement or on clear.
- Simultaneous events: enable=0 takes priority over an edge in the same cycle (no valid; go to IDLE).
- enable does not gate the synchroniser, so no spurious edge is generated when enable rises while pulse_in is already high.

Test Plan:
1. Drive pulse_in from a rate divider with D=5 (high 1 of every 5 cycles), enable=1 -> first valid after the second edge; period_out=5; valid one cycle every 5 cycles; locked=1 from the second valid onward; overflow=0.
2. Square wave with 1 cycle high, 1 cycle low -> period_out=2 and valid every 2 cycles. Then switch to period 7 -> next valid reports 7 with locked=0; the following valid reports 7 with locked=1.
3. WIDTH=4: two edges 20 cycles apart -> overflow=1 after 15 cycles idle in MEASURE, FSM returns to ARMED, no valid. Two further edges 6 apart -> period_out=6, valid=1, overflow=0. Separately, edges exactly 15 apart -> period_out=15 and no overflow.
4. Assert clear for 1 cycle asynchronously, between clock edges, during MEASURE -> all outputs go to 0 immediately. The next measurement requires two new edges.
5. Drop enable mid-measurement, then raise it while pulse_in is high -> no valid, no spurious edge, locked=0. Measurement resumes after two subsequent rising edges with the correct period.
6. pulse_in held high continuously after one rising edge, WIDTH=4 -> no valid; overflow=1 after 15 cycles.
